lc3_mem_arbiter: RTL
====================

# lc3_mem_arbiter

Arbiter and sequencer for the LC-3 single-ported unified memory. It shares one memory port between two requesters: the instruction-fetch path (Fetch state) and the data path (Read Memory, Write Memory and Indirect Read states). It also generates the per-requester `complete` strobe that the controller uses to leave a memory state. Each access runs for a fixed, parameterised memory latency, and simultaneous requests are resolved round-robin.

## Interface
- `MEM_LAT`, 2: cycles `mem_en` is held per access (legal 1..15).
- `AW`, 16: address width.
- `DW`, 16: data width.

Ports:
- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `f_req` in 1: fetch request, level, held until `f_complete`.
- `f_addr` in AW: fetch address (PC).
- `d_req` in 1: data request, level, held until `d_complete`.
- `d_we` in 1: data write enable (1 = write).
- `d_addr` in AW: data address (MAR).
- `d_wdata` in DW: write data (MDR).
- `f_complete` out 1: one-cycle pulse, fetch access finished.
- `d_complete` out 1: one-cycle pulse, data access finished.
- `rdata` out DW: data from the last read; holds between reads.
- `busy` out 1: high in ACCESS and DONE.
- `mem_en` out 1: memory enable.
- `mem_we` out 1: memory write enable.
- `mem_addr` out AW: memory address.
- `mem_wdata` out DW: memory write data.
- `mem_rdata` in DW: memory read data, valid in the last `mem_en` cycle.

## Operation
- FSM states: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE:
  - If only one request is high, grant it.
  - If both are high, grant the requester not served last. A `last` flag resets to DATA, so fetch wins the first tie.
  - On grant: latch addr, we and wdata, set `owner`, update `last`, load `cnt = MEM_LAT-1`, go to ACCESS.
- ACCESS:
  - `mem_en=1`, `mem_we=` latched we (fetch forces 0), `mem_addr` and `mem_wdata` from the latches.
  - `cnt` decrements each cycle.
  - When `cnt==0`: if read, capture `mem_rdata` into `rdata`; go to DONE.
- DONE:
  - `mem_en=0`, `mem_we=0`.
  - The owner's complete pulses high for exactly this cycle; next state is IDLE.
- Request deasserted mid-access: the access still finishes and complete still pulses. There is no abort.
- A request still high in the IDLE cycle after DONE is treated as a new request. Requesters must drop the request in the DONE cycle.
- Writes leave `rdata` unchanged.
- Input changes after the grant are ignored until the next grant.
- Reset value of every output is 0: `f_complete`, `d_complete`, `rdata`, `busy`, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`. Internally, state = IDLE, `cnt` = 0, `last` = DATA.
- Reset mid-access abandons the transaction immediately: `mem_en` drops asynchronously and no complete is issued.

## Timing
- Request sampled at edge E0 while in IDLE.
- `mem_en` is high for cycles E0+1 .. E0+MEM_LAT.
- Complete is high in cycle E0+MEM_LAT+1.
- Back at IDLE at E0+MEM_LAT+2.
- Latency from request to complete is MEM_LAT+1 cycles. Throughput is one access per MEM_LAT+2 cycles.
- With `MEM_LAT=1`: one cycle of `mem_en`, complete in the next cycle.
- `busy` is high exactly in the ACCESS and DONE cycles.
- Requests arriving during ACCESS or DONE wait and are arbitrated in the next IDLE cycle.

## Structure
- Shared package `lc3_mem_pkg` holds:
  - the state encoding (IDLE=2'b00, ACCESS=2'b01, DONE=2'b10);
  - requester IDs (OWN_FETCH=0, OWN_DATA=1);
  - default `AW`/`DW`.
- One natural sub-module, `lc3_rr_pick`: combinational two-way round-robin pick taking `f_req`, `d_req` and `last`, returning grant and owner.
- Counter, latches and FSM stay in the top module.

## Test plan
- **Single fetch read:** `MEM_LAT=2`, `f_req=1`, `f_addr=16'h3000`, memory returns 16'h1234 → `mem_en` high 2 cycles with `mem_addr=16'h3000` and `mem_we=0`; `f_complete` pulses on the 3rd cycle after the request edge; `rdata=16'h1234`; `d_complete` stays 0.
- **Data write:** `d_req=1`, `d_we=1`, `d_addr=16'h4000`, `d_wdata=16'hBEEF` → `mem_we=1` and `mem_wdata=16'hBEEF` for 2 cycles; `d_complete` pulses once; `rdata` keeps its previous value.
- **Round-robin:** both requests held high continuously after reset → grant order fetch, data, fetch, data, with accesses 4 cycles apart (`MEM_LAT=2`).
- **Late arrival:** `d_req` rises during a fetch ACCESS → served only after the fetch DONE, starting exactly at the next IDLE cycle.
- **Early drop:** `f_req` dropped after 1 cycle of ACCESS → access runs to completion and `f_complete` still pulses.
- **Reset mid-access:** `reset` asserted during ACCESS → `mem_en`, `busy` and `rdata` are 0 immediately (asynchronously); no complete pulse; a fresh `f_req` after reset is served normally.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// rtl/lc3_mem_pkg.sv - shared encodings and defaults for the LC-3 memory arbiter
package lc3_mem_pkg;

  // Sequencer states; the encoding is fixed so other blocks can decode it.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_t;

  // Requester identifiers, also the encoding of the round-robin "last" flag.
  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  // Default LC-3 address and data widths.
  localparam int DEF_AW = 16;
  localparam int DEF_DW = 16;

endpackage

// File: rtl/lc3_rr_pick.sv
// rtl/lc3_rr_pick.sv - two-way round-robin pick between fetch and data requests
module lc3_rr_pick
  import lc3_mem_pkg::*;
(
  input  logic f_req,
  input  logic d_req,
  input  logic last,
  output logic grant,
  output logic owner
);

  // A lone request wins outright; on a tie the requester not served last wins.
  always_comb begin
    grant = f_req | d_req;
    owner = OWN_FETCH;
    if (f_req && d_req) begin
      owner = (last == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
    end else if (d_req) begin
      owner = OWN_DATA;
    end
  end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// rtl/lc3_mem_arbiter.sv - shares the LC-3 memory port between fetch and data paths
module lc3_mem_arbiter
  import lc3_mem_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          f_complete,
  output logic          d_complete,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  // Counter reload: ACCESS lasts cnt+1 cycles, so load one less than the latency.
  localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          owner_q, owner_d;

  logic          f_complete_d;
  logic          d_complete_d;
  logic [DW-1:0] rdata_d;
  logic          busy_d;
  logic          mem_en_d;
  logic          mem_we_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d;

  logic          pick_grant;
  logic          pick_owner;

  lc3_rr_pick u_pick (
    .f_req (f_req),
    .d_req (d_req),
    .last  (last_q),
    .grant (pick_grant),
    .owner (pick_owner)
  );

  // Next-state and next-output logic; every output is registered from these.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    owner_d      = owner_q;
    f_complete_d = 1'b0;
    d_complete_d = 1'b0;
    rdata_d      = rdata;
    busy_d       = busy;
    mem_en_d     = mem_en;
    mem_we_d     = mem_we;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;

    case (state_q)
      ST_IDLE: begin
        busy_d   = 1'b0;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        if (pick_grant) begin
          state_d  = ST_ACCESS;
          owner_d  = pick_owner;
          last_d   = pick_owner;
          cnt_d    = CNT_LOAD;
          busy_d   = 1'b1;
          mem_en_d = 1'b1;
          if (pick_owner == OWN_DATA) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            // Instruction fetch is always a read.
            mem_we_d    = 1'b0;
            mem_addr_d  = f_addr;
            mem_wdata_d = '0;
          end
        end
      end

      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d  = ST_DONE;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          // Read data is valid in the last enable cycle; writes keep rdata.
          if (!mem_we) begin
            rdata_d = mem_rdata;
          end
          if (owner_q == OWN_FETCH) begin
            f_complete_d = 1'b1;
          end else begin
            d_complete_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d  = ST_IDLE;
        busy_d   = 1'b0;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any access immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      last_q     <= OWN_DATA;
      owner_q    <= OWN_FETCH;
      f_complete <= 1'b0;
      d_complete <= 1'b0;
      rdata      <= '0;
      busy       <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      f_complete <= f_complete_d;
      d_complete <= d_complete_d;
      rdata      <= rdata_d;
      busy       <= busy_d;
      mem_en     <= mem_en_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
    end
  end

endmodule
